// File: rtl/victim_sched_pkg.sv
// Shared types and constants for the victim scheduler.
// Holds the FSM state encoding, default widths and the LFSR seed/taps.
// Imported by the interface, the LFSR and the scheduler top.
package victim_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PICK   = 2'd1,
    SEARCH = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int NREQ_DEF      = 4;
  localparam int WAYS_DEF      = 4;
  localparam int LFSR_BITS_DEF = 5;

  // Non-zero seed so the generator never locks up at all-zeros.
  localparam logic [LFSR_BITS_DEF-1:0] LFSR_SEED = 5'h1f;

  // Feedback taps: new msb = q[TAP_HI] ^ q[TAP_LO].
  localparam int LFSR_TAP_HI = 4;
  localparam int LFSR_TAP_LO = 1;

endpackage

// File: rtl/victim_scheduler_if.sv
// Request/response bundle between bank miss handlers and the victim scheduler.
// Latency: none (wires only).
// Backpressure: req side valid/ready per bank, resp side single valid/ready.
interface victim_scheduler_if
  import victim_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int WAYS = WAYS_DEF
);
  localparam int ID_W  = $clog2(NREQ);
  localparam int WAY_W = $clog2(WAYS);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*WAYS-1:0] req_way_valid;
  logic [NREQ*WAYS-1:0] req_way_lock;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic [WAY_W-1:0]     resp_way;
  logic                 resp_fail;

  // Miss handlers / result consumer side.
  modport master (
    output req_valid, req_way_valid, req_way_lock, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_way, resp_fail
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_way_valid, req_way_lock, resp_ready,
    output req_ready, resp_valid, resp_id, resp_way, resp_fail
  );

endinterface

// File: rtl/victim_lfsr.sv
// Fibonacci LFSR feeding random victim candidates.
// Latency: new value visible the cycle after advance.
// Backpressure: none; holds its value while advance is low.
module victim_lfsr
  import victim_sched_pkg::*;
#(
  parameter int BITS = LFSR_BITS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  output logic [BITS-1:0] q
);

  // Shift right, feed the tap xor into the msb; reseed on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_SEED[BITS-1:0];
    end else if (advance) begin
      q <= {q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO], q[BITS-1:1]};
    end
  end

endmodule

// File: rtl/victim_scheduler.sv
// Round-robin shared victim picker: free unlocked way first, else random unlocked way.
// Latency: response 2 cycles after grant, plus one per locked-candidate search step.
// Backpressure: one request in flight; no grants until the response is accepted.
module victim_scheduler
  import victim_sched_pkg::*;
#(
  parameter  int NREQ      = NREQ_DEF,
  parameter  int WAYS      = WAYS_DEF,
  parameter  int LFSR_BITS = LFSR_BITS_DEF,
  localparam int WAY_W     = $clog2(WAYS),
  localparam int ID_W      = $clog2(NREQ)
) (
  input logic               clk,
  input logic               rst,
  victim_scheduler_if.slave bus
);

  state_t               state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      id_q;
  logic [WAYS-1:0]      valid_q;
  logic [WAYS-1:0]      lock_q;
  logic [WAY_W-1:0]     cand_q;
  logic                 resp_valid_q;
  logic [WAY_W-1:0]     resp_way_q;
  logic                 resp_fail_q;

  logic                 grant_vld;
  logic [ID_W-1:0]      grant_id;
  int                   rr_idx;
  logic [WAYS-1:0]      free;
  logic [WAY_W-1:0]     free_idx;
  logic [LFSR_BITS-1:0] lfsr_q;
  logic [WAY_W-1:0]     lfsr_cand;
  logic                 lfsr_adv;

  // First requesting bank at or after rr_ptr; lower offsets overwrite later ones.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    rr_idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      rr_idx = int'(rr_ptr) + k;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      if (bus.req_valid[rr_idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(rr_idx);
      end
    end
  end

  // One-hot grant, only while idle so a single request is ever in flight.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && !rst && grant_vld) bus.req_ready[grant_id] = 1'b1;
  end

  // Lowest free way, plus the random candidate and when the generator steps.
  always_comb begin
    free     = ~valid_q & ~lock_q;
    free_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (free[w]) free_idx = WAY_W'(w);
    end
    // WAYS is a power of two, so masking equals taking the low WAY_W bits.
    lfsr_cand = WAY_W'(lfsr_q & LFSR_BITS'(WAYS - 1));
    lfsr_adv  = (state == PICK) && (free == '0) && !(&lock_q);
  end

  victim_lfsr #(.BITS(LFSR_BITS)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .advance(lfsr_adv),
    .q      (lfsr_q)
  );

  // Scheduler FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      id_q         <= '0;
      valid_q      <= '0;
      lock_q       <= '0;
      cand_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_way_q   <= '0;
      resp_fail_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            id_q    <= grant_id;
            valid_q <= bus.req_way_valid[grant_id*WAYS +: WAYS];
            lock_q  <= bus.req_way_lock[grant_id*WAYS +: WAYS];
            state   <= PICK;
          end
        end
        PICK: begin
          if (free != '0) begin
            resp_way_q   <= free_idx;
            resp_fail_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end else if (&lock_q) begin
            resp_way_q   <= '0;
            resp_fail_q  <= 1'b1;
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end else if (!lock_q[lfsr_cand]) begin
            resp_way_q   <= lfsr_cand;
            resp_fail_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end else begin
            cand_q <= lfsr_cand + 1'b1;
            state  <= SEARCH;
          end
        end
        SEARCH: begin
          // Some way is unlocked here, so this terminates within WAYS-1 steps.
          if (!lock_q[cand_q]) begin
            resp_way_q   <= cand_q;
            resp_fail_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end else begin
            cand_q <= cand_q + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            rr_ptr       <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = id_q;
  assign bus.resp_way   = resp_way_q;
  assign bus.resp_fail  = resp_fail_q;

endmodule

// File: tb/tb_victim_scheduler.sv
// Bench for victim_scheduler: vector table plus round-robin and mid-operation reset sequences.
// Expected responses are queued at grant time and compared when the response appears.
// Waits are bounded; a stuck DUT shows up as failed comparisons.
module tb_victim_scheduler;

  logic clk;
  logic rst;
  int   cyc;
  int   n_assert;
  int   n_fail;

  victim_scheduler_if #(.NREQ(4), .WAYS(4)) bus ();

  victim_scheduler #(.NREQ(4), .WAYS(4), .LFSR_BITS(5)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         id;
    logic [1:0] way;
    logic       fail;
    int         t;
  } exp_t;

  typedef struct {
    bit         do_rst;
    int         bank;
    logic [3:0] vm;
    logic [3:0] lm;
    int         lat;
    logic [1:0] way;
    logic       fail;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Holds reset two cycles, checks the output reset state, returns at posedge+1.
  task automatic reset_dut();
    rst = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_fields", {bus.resp_id, bus.resp_way, bus.resp_fail}, 5'd0);
    chk("rst_req_ready", bus.req_ready, 4'd0);
    @(posedge clk);
    #1;
    sb.delete();
  endtask

  // Waits for the grant, checks it is immediate and one-hot on the expected bank, queues the result.
  task automatic wait_grant(input logic [3:0] exp_grant, input int lat,
                            input logic [1:0] way, input logic fail);
    int n = 0;
    int id = 0;
    @(negedge clk);
    while (bus.req_ready == 4'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant_vec", bus.req_ready, exp_grant);
    chk("grant_delay", n, 0);
    for (int b = 0; b < 4; b++) if (exp_grant[b]) id = b;
    sb.push_back('{id, way, fail, cyc + lat});
  endtask

  // Waits for a response, compares with the queue head, optionally stalls, then accepts it.
  task automatic wait_resp(input int hold);
    int   n = 0;
    exp_t e = '{0, 2'd0, 1'b0, 0};
    @(negedge clk);
    while (!bus.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("resp_valid", bus.resp_valid, 1'b1);
    if (sb.size() == 0) begin
      chk("resp_unexpected", bus.resp_valid, 1'b0);
    end else begin
      e = sb.pop_front();
      chk("resp_cycle", cyc, e.t);
      chk("resp_id", bus.resp_id, e.id);
      chk("resp_way", bus.resp_way, e.way);
      chk("resp_fail", bus.resp_fail, e.fail);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("resp_hold", {bus.resp_valid, bus.resp_id, bus.resp_way, bus.resp_fail},
          {1'b1, 2'(e.id), e.way, e.fail});
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cyc = 0;
    n_assert = 0;
    n_fail = 0;
    bus.req_valid     = '0;
    bus.req_way_valid = '0;
    bus.req_way_lock  = '0;
    bus.resp_ready    = 1'b0;

    // LFSR walk from seed: 1f,0f,17,0b,15,1a,0d,06 -> candidates 3,3,3,3,1,2,1,2
    tbl[0]  = '{1'b1, 0, 4'b1011, 4'b0000, 2, 2'd2, 1'b0}; // free way 2, no LFSR step
    tbl[1]  = '{1'b0, 1, 4'hf,    4'h0,    2, 2'd3, 1'b0}; // lfsr 1f
    tbl[2]  = '{1'b0, 1, 4'hf,    4'h0,    2, 2'd3, 1'b0}; // 0f
    tbl[3]  = '{1'b0, 1, 4'hf,    4'h0,    2, 2'd3, 1'b0}; // 17
    tbl[4]  = '{1'b0, 1, 4'hf,    4'h0,    2, 2'd3, 1'b0}; // 0b
    tbl[5]  = '{1'b0, 1, 4'hf,    4'h0,    2, 2'd1, 1'b0}; // 15
    tbl[6]  = '{1'b0, 1, 4'hf,    4'h0,    2, 2'd2, 1'b0}; // 1a
    tbl[7]  = '{1'b1, 2, 4'hf,    4'b1000, 3, 2'd0, 1'b0}; // 1f: cand 3 locked, one search
    tbl[8]  = '{1'b0, 2, 4'hf,    4'h0,    2, 2'd3, 1'b0}; // 0f
    tbl[9]  = '{1'b0, 2, 4'hf,    4'h0,    2, 2'd3, 1'b0}; // 17
    tbl[10] = '{1'b0, 3, 4'hf,    4'hf,    2, 2'd0, 1'b1}; // all locked, no step
    tbl[11] = '{1'b0, 3, 4'hf,    4'h0,    2, 2'd3, 1'b0}; // still 0b
    tbl[12] = '{1'b0, 0, 4'hf,    4'b1110, 5, 2'd0, 1'b0}; // 15: cand 1, search 2,3,0
    tbl[13] = '{1'b0, 0, 4'hf,    4'b0101, 3, 2'd3, 1'b0}; // 1a: cand 2 locked, search 3
    tbl[14] = '{1'b0, 1, 4'b0111, 4'b1000, 2, 2'd1, 1'b0}; // 0d: cand 1 unlocked
    tbl[15] = '{1'b0, 2, 4'b0000, 4'b0011, 2, 2'd2, 1'b0}; // free but locked low ways

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].do_rst) reset_dut();
      bus.req_way_valid[tbl[i].bank*4 +: 4] = tbl[i].vm;
      bus.req_way_lock[tbl[i].bank*4 +: 4]  = tbl[i].lm;
      bus.req_valid = 4'b0001 << tbl[i].bank;
      wait_grant(4'b0001 << tbl[i].bank, tbl[i].lat, tbl[i].way, tbl[i].fail);
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      // Masks changing after the grant must not affect the result.
      bus.req_way_valid[tbl[i].bank*4 +: 4] = ~tbl[i].vm;
      bus.req_way_lock[tbl[i].bank*4 +: 4]  = ~tbl[i].lm;
      wait_resp(0);
    end

    // Round-robin, backpressure and back-to-back grants; all ways free -> way 0.
    reset_dut();
    bus.req_way_valid = '0;
    bus.req_way_lock  = '0;
    bus.req_valid = 4'b0101;
    wait_grant(4'b0001, 2, 2'd0, 1'b0);
    @(negedge clk);
    chk("busy_req_ready", bus.req_ready, 4'd0);
    bus.resp_ready = 1'b1;            // ignored outside RESP
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    wait_resp(5);
    wait_grant(4'b0100, 2, 2'd0, 1'b0);
    wait_resp(0);
    bus.req_valid = 4'b0011;          // rr_ptr 3 wraps to bank 0
    wait_grant(4'b0001, 2, 2'd0, 1'b0);
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_resp(0);

    // Reset in SEARCH drops the request and restores power-up behaviour.
    reset_dut();
    bus.req_way_valid = {4{4'hf}};
    bus.req_way_lock  = '0;
    bus.req_valid = 4'b0010;
    wait_grant(4'b0010, 2, 2'd3, 1'b0);   // lfsr 1f -> 0f, rr_ptr -> 2
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_resp(0);
    bus.req_way_lock[3:0] = 4'b1000;
    bus.req_valid = 4'b0001;
    wait_grant(4'b0001, 3, 2'd0, 1'b0);   // 0f: cand 3 locked -> SEARCH
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    chk("pick_req_ready", bus.req_ready, 4'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("search_resp_valid", bus.resp_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_resp_valid", bus.resp_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.req_way_lock = '0;
    bus.req_valid = 4'b0111;              // rr_ptr back to 0 -> bank 0
    wait_grant(4'b0001, 2, 2'd3, 1'b0);
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_resp(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
